// File: rtl/load_store_sequencer.sv
// Multi-cycle load/store sequencer for SPARC V8 format-3 memory instructions.
// Drives MAR/MDR/RAM/register-file strobes for one transaction and waits on the RAM MFC handshake.
module load_store_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Start,
    input  logic [31:0] IR_Out,
    input  logic [31:0] ALU_Out,
    input  logic        MFC,
    output logic        MAR_Enable,
    output logic        MDR_Enable,
    output logic        MDR_Mux_select,
    output logic        RAM_enable,
    output logic [5:0]  RAM_OpCode,
    output logic        register_file_enable,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [1:0]  Err_code
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
    localparam logic [1:0] ERR_MISALIGN  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_MEM,
        S_LATCH,
        S_WB,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [5:0]      op3_reg, op3_next;
    logic [1:0]      err_code_reg, err_code_next;

    logic            ir_legal;
    logic            is_store;
    logic            misaligned;
    logic            timeout_hit;
    logic            unused_bits;

    // Only op and op3 of the instruction, and the low address bits, matter here.
    assign unused_bits = ^{IR_Out[29:25], IR_Out[18:0], ALU_Out[31:2]};

    always_comb begin
        ir_legal = 1'b0;
        if (IR_Out[31:30] == 2'b11) begin
            case (IR_Out[24:19])
                6'b000000, 6'b000001, 6'b000010,
                6'b000100, 6'b000101, 6'b000110: ir_legal = 1'b1;
                default:                         ir_legal = 1'b0;
            endcase
        end
    end

    // Legal op3 encodings: bit 2 selects store, bits 1:0 give size (00 word, 01 byte, 10 half).
    assign is_store = op3_reg[2];

    always_comb begin
        misaligned = 1'b0;
        case (op3_reg[1:0])
            2'b00:   misaligned = (ALU_Out[1:0] != 2'b00);
            2'b10:   misaligned = ALU_Out[0];
            default: misaligned = 1'b0;
        endcase
    end

    assign timeout_hit = (wait_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            op3_reg      <= '0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            op3_reg      <= op3_next;
            err_code_reg <= err_code_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        wait_cnt_next        = wait_cnt_reg;
        op3_next             = op3_reg;
        err_code_next        = err_code_reg;
        MAR_Enable           = 1'b0;
        MDR_Enable           = 1'b0;
        MDR_Mux_select       = 1'b0;
        RAM_enable           = 1'b0;
        register_file_enable = 1'b0;
        Done                 = 1'b0;
        Error                = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (Start) begin
                    op3_next = IR_Out[24:19];
                    if (ir_legal) begin
                        state_next    = S_ADDR;
                        err_code_next = ERR_NONE;
                    end else begin
                        state_next    = S_ERR;
                        err_code_next = ERR_ILLEGAL;
                    end
                end
            end
            S_ADDR: begin
                MAR_Enable = 1'b1;
                if (misaligned) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_MISALIGN;
                end else if (is_store) begin
                    state_next = S_WDATA;
                end else begin
                    state_next    = S_MEM;
                    wait_cnt_next = '0;
                end
            end
            S_WDATA: begin
                MDR_Enable    = 1'b1;
                state_next    = S_MEM;
                wait_cnt_next = '0;
            end
            S_MEM: begin
                RAM_enable    = 1'b1;
                wait_cnt_next = wait_cnt_reg + 1'b1;
                // A late MFC still completes the access even on the last allowed cycle.
                if (MFC) begin
                    state_next = is_store ? S_DONE : S_LATCH;
                end else if (timeout_hit) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_LATCH: begin
                RAM_enable     = 1'b1;
                MDR_Enable     = 1'b1;
                MDR_Mux_select = 1'b1;
                state_next     = S_WB;
            end
            S_WB: begin
                register_file_enable = 1'b1;
                state_next           = S_DONE;
            end
            S_DONE: begin
                Done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                Error      = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign Busy       = (state_reg != S_IDLE);
    assign RAM_OpCode = op3_reg;
    assign Err_code   = err_code_reg;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: directed scenarios then random transactions, each checked
// cycle by cycle against an expected output schedule derived from the instruction rules.
module tb_load_store_sequencer;

    localparam int TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        Start;
    logic [31:0] IR_Out;
    logic [31:0] ALU_Out;
    logic        MFC;
    logic        MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic        register_file_enable, Busy, Done, Error;
    logic [1:0]  Err_code;

    int compared   = 0;
    int mismatched = 0;
    int txn_no     = 0;

    // Expected strobe vector: {MAR, MDR, sel, RAM, rf, Busy, Done, Error}
    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_ADDR  = 8'b1000_0100;
    localparam logic [7:0] V_WDATA = 8'b0100_0100;
    localparam logic [7:0] V_MEM   = 8'b0001_0100;
    localparam logic [7:0] V_LATCH = 8'b0111_0100;
    localparam logic [7:0] V_WB    = 8'b0000_1100;
    localparam logic [7:0] V_DONE  = 8'b0000_0110;
    localparam logic [7:0] V_ERR   = 8'b0000_0101;

    localparam logic [5:0] LD = 6'b000000, LDUB = 6'b000001, LDUH = 6'b000010;
    localparam logic [5:0] ST = 6'b000100, STB = 6'b000101, STH = 6'b000110;

    load_store_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .Clk                  (Clk),
        .Clr                  (Clr),
        .Start                (Start),
        .IR_Out               (IR_Out),
        .ALU_Out              (ALU_Out),
        .MFC                  (MFC),
        .MAR_Enable           (MAR_Enable),
        .MDR_Enable           (MDR_Enable),
        .MDR_Mux_select       (MDR_Mux_select),
        .RAM_enable           (RAM_enable),
        .RAM_OpCode           (RAM_OpCode),
        .register_file_enable (register_file_enable),
        .Busy                 (Busy),
        .Done                 (Done),
        .Error                (Error),
        .Err_code             (Err_code)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] strobes();
        return {MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable,
                register_file_enable, Busy, Done, Error};
    endfunction

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL txn%0d %s c%0d observed=%h expected=%h", txn_no, tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] make_ir(input logic [1:0] op, input logic [5:0] op3);
        logic [31:0] w;
        w = $urandom;
        w[31:30] = op;
        w[24:19] = op3;
        return w;
    endfunction

    // Runs one transaction. mfc_delay = MEM cycles with MFC low before it rises (>= TIMEOUT never rises).
    // clr_at > 0 pulses Clr after checking cycle clr_at.
    task automatic run(input logic [31:0] ir, input logic [31:0] addr, input int mfc_delay, input int clr_at);
        logic [7:0] vq[$];
        logic [1:0] eq[$];
        logic [5:0] op3;
        logic       legal, store, mis;
        int         nmem, memidx;

        txn_no++;
        op3   = ir[24:19];
        legal = (ir[31:30] == 2'b11) && (op3 inside {LD, LDUB, LDUH, ST, STB, STH});
        store = op3 inside {ST, STB, STH};
        mis   = ((op3 inside {LD, ST}) && (addr[1:0] != 2'b00)) ||
                ((op3 inside {LDUH, STH}) && addr[0]);

        vq.push_back(V_IDLE); eq.push_back(2'b00);   // index 0 unused (edge 0)
        if (!legal) begin
            vq.push_back(V_ERR); eq.push_back(2'b01);
        end else begin
            vq.push_back(V_ADDR); eq.push_back(2'b00);
            if (mis) begin
                vq.push_back(V_ERR); eq.push_back(2'b10);
            end else begin
                if (store) begin vq.push_back(V_WDATA); eq.push_back(2'b00); end
                nmem = (mfc_delay < TIMEOUT) ? mfc_delay + 1 : TIMEOUT;
                for (int k = 0; k < nmem; k++) begin vq.push_back(V_MEM); eq.push_back(2'b00); end
                if (mfc_delay < TIMEOUT) begin
                    if (!store) begin
                        vq.push_back(V_LATCH); eq.push_back(2'b00);
                        vq.push_back(V_WB);    eq.push_back(2'b00);
                    end
                    vq.push_back(V_DONE); eq.push_back(2'b00);
                end else begin
                    vq.push_back(V_ERR); eq.push_back(2'b11);
                end
            end
        end

        Start   = 1'b1;
        IR_Out  = ir;
        ALU_Out = addr;
        MFC     = 1'($urandom);
        memidx  = 0;

        for (int n = 1; n < vq.size(); n++) begin
            @(posedge Clk);
            @(negedge Clk);
            check("strobes", n, 32'(strobes()), 32'(vq[n]));
            check("opcode", n, 32'(RAM_OpCode), 32'(op3));
            check("errcode", n, 32'(Err_code), 32'(eq[n]));

            // Busy-time inputs are noise: Start, IR and (after ADDR) ALU_Out must be ignored.
            Start  = 1'($urandom);
            IR_Out = $urandom;
            if (n >= 2) ALU_Out = $urandom;
            if (vq[n] == V_MEM) begin
                MFC = (memidx == mfc_delay);
                memidx++;
            end else begin
                MFC = 1'($urandom);
            end

            if (n == clr_at) begin
                Clr   = 1'b1;
                Start = 1'b0;
                @(posedge Clk);
                @(negedge Clk);
                check("clr_strobes", n + 1, 32'(strobes()), 32'(V_IDLE));
                check("clr_opcode", n + 1, 32'(RAM_OpCode), 32'd0);
                check("clr_errcode", n + 1, 32'(Err_code), 32'd0);
                Clr = 1'b0;
                $display("txn%0d ir=%h addr=%h delay=%0d aborted by Clr at c%0d", txn_no, ir, addr, mfc_delay, n);
                return;
            end
        end

        @(posedge Clk);
        @(negedge Clk);
        check("idle_strobes", vq.size(), 32'(strobes()), 32'(V_IDLE));
        check("idle_errcode", vq.size(), 32'(Err_code), 32'(eq[vq.size() - 1]));
        check("idle_opcode", vq.size(), 32'(RAM_OpCode), 32'(op3));
        Start = 1'b0;
        MFC   = 1'b0;
        $display("txn%0d ir=%h addr=%h delay=%0d cycles=%0d errcode=%b", txn_no, ir, addr, mfc_delay,
                 vq.size() - 1, eq[vq.size() - 1]);
    endtask

    initial begin
        logic [5:0]  legal_ops [6];
        logic [5:0]  op3;
        logic [1:0]  op;

        legal_ops = '{LD, LDUB, LDUH, ST, STB, STH};
        Clr = 1'b1; Start = 1'b0; IR_Out = '0; ALU_Out = '0; MFC = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_strobes", 0, 32'(strobes()), 32'(V_IDLE));
        check("reset_opcode", 0, 32'(RAM_OpCode), 32'd0);
        check("reset_errcode", 0, 32'(Err_code), 32'd0);
        Clr = 1'b0;
        @(negedge Clk);

        run(make_ir(2'b11, LD),   32'h0000_0010, 0, 0);
        run(make_ir(2'b11, STB),  32'h0000_0003, 3, 0);
        run(make_ir(2'b11, LDUH), 32'h0000_0005, 0, 0);
        run(32'h8200_4002,        32'h0000_0000, 0, 0);
        run(make_ir(2'b11, ST),   32'h0000_0020, TIMEOUT, 0);
        run(make_ir(2'b11, LD),   32'h0000_0024, 0, 0);
        run(make_ir(2'b11, LD),   32'h0000_0040, 5, 3);
        run(make_ir(2'b11, LD),   32'h0000_0044, 0, 0);
        run(make_ir(2'b11, LDUB), 32'h0000_0047, TIMEOUT - 1, 0);
        run(make_ir(2'b11, STH),  32'h0000_0006, 2, 0);
        run(make_ir(2'b11, 6'b000011), 32'h0000_0008, 0, 0);  // LDD is illegal
        run(make_ir(2'b11, 6'b000111), 32'h0000_0008, 0, 0);  // STD is illegal

        for (int t = 0; t < 200; t++) begin
            op  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
            op3 = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
            run(make_ir(op, op3), $urandom, $urandom_range(0, TIMEOUT + 1),
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_sequencer.md
# load_store_sequencer

Multi-cycle sequencer for SPARC V8 format-3 load/store instructions (op = 2'b11). It sits between the ControlUnit and the DataPath. It drives the MAR/MDR/RAM/register-file enables and mux selects for one memory transaction at a time, and waits on the RAM MFC handshake. It also flags illegal opcodes, misaligned addresses and memory timeouts.

## Interface

Parameters:
- TIMEOUT, 16: maximum number of MEM-state cycles to wait for MFC before aborting.

Ports:
- Clk  in  1  system clock; every register updates on the rising edge.
- Clr  in  1  synchronous, active-high reset.
- Start  in  1  request to execute the instruction on IR_Out; sampled only in IDLE.
- IR_Out  in  32  current instruction word.
- ALU_Out  in  32  effective address (rs1 + rs2/simm13); sampled in ADDR.
- MFC  in  1  memory function complete, from RAM.
- MAR_Enable  out  1  load MAR from ALU_Out.
- MDR_Enable  out  1  load MDR.
- MDR_Mux_select  out  1  MDR source: 0 = register file (store data), 1 = RAM (load data).
- RAM_enable  out  1  RAM access strobe.
- RAM_OpCode  out  6  latched op3, passed to RAM.
- register_file_enable  out  1  write rd.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on successful completion.
- Error  out  1  one-cycle pulse on abort.
- Err_code  out  2  reason for the abort; held until the next Start: 01 illegal op, 10 misaligned, 11 timeout, 00 none.

## Operation

- Legal op3 values: LD 000000, LDUB 000001, LDUH 000010, ST 000100, STB 000101, STH 000110. Any other op3, including LDD and STD, is illegal. op ≠ 2'b11 is also illegal.
- On Start in IDLE: IR_Out[24:19] (op3) is latched into RAM_OpCode. Later changes to IR_Out do not affect the transaction.
- Alignment rules:
  - word (LD, ST): ALU_Out[1:0] must be 00.
  - half (LDUH, STH): ALU_Out[0] must be 0.
  - byte (LDUB, STB): always aligned.
- FSM (Moore; all outputs are decoded from the state register only):
  - IDLE: all strobes 0. Start & legal → ADDR. Start & illegal → ERR with code 01.
  - ADDR: MAR_Enable=1. Misaligned → ERR with code 10. Otherwise store → WDATA, load → MEM.
  - WDATA: MDR_Enable=1, MDR_Mux_select=0 → MEM.
  - MEM: RAM_enable=1; the wait counter increments each cycle.
    - MFC=1 → LATCH for a load, DONE for a store.
    - Otherwise, counter = TIMEOUT−1 → ERR with code 11.
  - LATCH: RAM_enable=1, MDR_Enable=1, MDR_Mux_select=1 → WB.
  - WB: register_file_enable=1 → DONE.
  - DONE: Done=1 → IDLE.
  - ERR: Error=1 → IDLE.
- MFC is ignored outside MEM.
- Start is ignored while Busy=1.
- The wait counter clears on entry to MEM. Its width is $clog2(TIMEOUT)+1.
- MFC and timeout in the same cycle: MFC wins, and the transaction completes normally.

## Timing

- Reset values (Clr=1 at a rising edge): state=IDLE, every output 0, RAM_OpCode=000000, Err_code=00, counter=0.
- Clr asserted mid-transaction aborts immediately to IDLE. No Done or Error pulse is produced.
- Count cycles from the edge that samples Start (edge 0):
  - Load, MFC high in the first MEM cycle: ADDR c1, MEM c2, LATCH c3, WB c4, Done c5.
  - Store, MFC high in the first MEM cycle: ADDR c1, WDATA c2, MEM c3, Done c4.
  - Each cycle that MFC stays low in MEM adds one cycle of latency.
  - Timeout: exactly TIMEOUT MEM cycles, then Error in the following cycle.
- Back-to-back: Start may be high during the Done cycle, but it is not accepted there. The earliest accepted Start is in the first IDLE cycle after Done or Error.
- Busy is high from c1 through the Done/Error cycle inclusive.

## Test plan

- LD, ALU_Out=0x00000010, MFC high on the first MEM cycle → MAR_Enable c1; RAM_enable c2–c3; MDR_Enable with select=1 c3; register_file_enable c4; Done c5; RAM_OpCode=000000.
- STB to 0x00000003 with MFC delayed 3 cycles → WDATA has select=0; 4 MEM cycles; Done at c7; Err_code=00.
- LDUH to 0x00000005 → Error in the cycle after ADDR, Err_code=10; RAM_enable never asserted.
- IR_Out=0x82004002 (op=10, arithmetic), Start=1 → Error at c1, Err_code=01, MAR_Enable never asserted.
- ST with MFC held low, TIMEOUT=16 → 16 MEM cycles, then Error with Err_code=11; a following LD completes normally.
- LD with Clr pulsed during MEM → next cycle every output is 0 and Busy=0; Start issued afterwards completes with Done at c5.
